// File: rtl/bundler_ctrl_if.sv
// Handshake and bundler-array bus for bundler_ctrl.
// slave is the controller side, master the environment side.
interface bundler_ctrl_if #(
    parameter int HVDimension   = 512,
    parameter int CounterWidth  = 8,
    parameter int NumItemsWidth = 16
);
    logic                              start_i;
    logic                              abort_i;
    logic [NumItemsWidth-1:0]          num_items_i;
    logic [HVDimension-1:0]            tie_break_i;
    logic [HVDimension-1:0]            hv_i;
    logic                              hv_valid_i;
    logic                              hv_ready_o;
    logic [HVDimension-1:0]            bund_bit_o;
    logic                              bund_valid_o;
    logic                              bund_clr_o;
    logic [HVDimension*CounterWidth-1:0] counters_i;
    logic [HVDimension-1:0]            result_o;
    logic                              result_valid_o;
    logic                              result_ready_i;
    logic                              busy_o;
    logic [NumItemsWidth-1:0]          items_left_o;

    modport slave (
        input  start_i, abort_i, num_items_i, tie_break_i,
        input  hv_i, hv_valid_i, counters_i, result_ready_i,
        output hv_ready_o, bund_bit_o, bund_valid_o, bund_clr_o,
        output result_o, result_valid_o, busy_o, items_left_o
    );

    modport master (
        output start_i, abort_i, num_items_i, tie_break_i,
        output hv_i, hv_valid_i, counters_i, result_ready_i,
        input  hv_ready_o, bund_bit_o, bund_valid_o, bund_clr_o,
        input  result_o, result_valid_o, busy_o, items_left_o
    );
endinterface

// File: rtl/bundler_ctrl.sv
// Sequencer for a bundler array: clear, accumulate N items,
// binarize the counters by sign and hand one result downstream.
module bundler_ctrl #(
    parameter int HVDimension   = 512,
    parameter int CounterWidth  = 8,
    parameter int NumItemsWidth = 16
) (
    input logic          clk_i,
    input logic          rst_ni,
    bundler_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_SETTLE,
        S_OUTPUT
    } state_t;

    state_t                   r_state;
    logic [NumItemsWidth-1:0] r_items_left;
    logic [HVDimension-1:0]   r_result;
    logic [HVDimension-1:0]   w_result;
    logic                     w_in_accum;
    logic                     w_accept;

    assign w_in_accum = (r_state == S_ACCUM) && !bus.abort_i;
    assign w_accept   = w_in_accum && bus.hv_valid_i;

    assign bus.hv_ready_o     = w_in_accum;
    assign bus.bund_valid_o   = w_accept;
    assign bus.bund_bit_o     = bus.hv_i;
    assign bus.bund_clr_o     = (r_state == S_CLEAR) || bus.abort_i;
    assign bus.result_valid_o = (r_state == S_OUTPUT) && !bus.abort_i;
    assign bus.result_o       = r_result;
    assign bus.busy_o         = (r_state != S_IDLE);
    assign bus.items_left_o   = r_items_left;

    // Sign threshold per unit; a zero counter takes the tie-break bit
    always_comb begin
        w_result = '0;
        for (int d = 0; d < HVDimension; d++) begin
            if (bus.counters_i[d*CounterWidth +: CounterWidth] == '0)
                w_result[d] = bus.tie_break_i[d];
            else
                w_result[d] = ~bus.counters_i[d*CounterWidth+CounterWidth-1];
        end
    end

    // Job FSM; abort overrides start and every handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_items_left <= '0;
            r_result     <= '0;
        end else if (bus.abort_i) begin
            r_state      <= S_IDLE;
            r_items_left <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_state      <= S_CLEAR;
                        r_items_left <= bus.num_items_i;
                    end
                end
                S_CLEAR: begin
                    if (r_items_left != '0)
                        r_state <= S_ACCUM;
                    else
                        r_state <= S_SETTLE;
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_items_left <= r_items_left - 1'b1;
                        if (r_items_left == NumItemsWidth'(1))
                            r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_result <= w_result;
                    r_state  <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (bus.result_ready_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bundler_ctrl.sv
// Self-checking bench for bundler_ctrl with a saturating
// bundler-array model and a queue-based bundle reference.
module tb_bundler_ctrl;
    localparam int HVD = 8;
    localparam int CW  = 8;
    localparam int NIW = 16;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    logic [HVD-1:0] q_items[$];

    bundler_ctrl_if #(
        .HVDimension(HVD), .CounterWidth(CW), .NumItemsWidth(NIW)
    ) bus ();

    bundler_ctrl #(
        .HVDimension(HVD), .CounterWidth(CW), .NumItemsWidth(NIW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bundler array environment: per-bit saturating counters
    logic signed [CW-1:0] cnt [HVD];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < HVD; d++) cnt[d] <= '0;
        end else if (bus.bund_clr_o) begin
            for (int d = 0; d < HVD; d++) cnt[d] <= '0;
        end else if (bus.bund_valid_o) begin
            for (int d = 0; d < HVD; d++) begin
                if (bus.bund_bit_o[d]) begin
                    if (cnt[d] != 8'sd127) cnt[d] <= cnt[d] + 8'sd1;
                end else begin
                    if (cnt[d] != -8'sd128) cnt[d] <= cnt[d] - 8'sd1;
                end
            end
        end
    end

    for (genvar g = 0; g < HVD; g++) begin : g_cnt
        assign bus.counters_i[g*CW +: CW] = cnt[g];
    end

    // Expected bundle: clamped running vote per bit, then sign
    function automatic logic [HVD-1:0] ref_bundle(
        input logic [HVD-1:0] items[$], input logic [HVD-1:0] tie);
        int s[HVD];
        logic [HVD-1:0] r;
        for (int d = 0; d < HVD; d++) s[d] = 0;
        foreach (items[i]) begin
            for (int d = 0; d < HVD; d++) begin
                if (items[i][d]) s[d] = (s[d] < 127) ? s[d] + 1 : 127;
                else             s[d] = (s[d] > -128) ? s[d] - 1 : -128;
            end
        end
        for (int d = 0; d < HVD; d++)
            r[d] = (s[d] > 0) ? 1'b1 : (s[d] < 0) ? 1'b0 : tie[d];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: no stalls, 1: valid toggles, 2: random valid
    task automatic run_job(input int n, input logic [HVD-1:0] tie,
                           input int mode, input int hold);
        int acc;
        int guard;
        int k0;
        logic v;
        logic [HVD-1:0] expv;
        expv = ref_bundle(q_items, tie);
        tick();
        bus.tie_break_i = tie;
        bus.num_items_i = NIW'(n);
        bus.start_i     = 1'b1;
        k0 = cyc;
        tick();
        bus.start_i = 1'b0;
        #3;
        chk("clear_clr", bus.bund_clr_o, 1);
        chk("clear_busy", bus.busy_o, 1);
        chk("clear_ready", bus.hv_ready_o, 0);
        chk("clear_left", bus.items_left_o, n);
        tick();
        acc = 0;
        guard = 0;
        while (acc < n && guard < 4000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            bus.hv_valid_i = v;
            bus.hv_i       = q_items[acc];
            #3;
            chk("accum_ready", bus.hv_ready_o, 1);
            chk("accum_left", bus.items_left_o, n - acc);
            chk("accum_bvalid", bus.bund_valid_o, v);
            chk("accum_bbit", bus.bund_bit_o, q_items[acc]);
            chk("accum_noclr", bus.bund_clr_o, 0);
            if (v) acc++;
            guard++;
            tick();
        end
        if (acc < n) chk("accum_timeout", acc, n);
        bus.hv_valid_i = 1'b0;
        bus.hv_i       = HVD'($urandom);
        #3;
        chk("settle_valid", bus.result_valid_o, 0);
        chk("settle_ready", bus.hv_ready_o, 0);
        chk("settle_left", bus.items_left_o, 0);
        chk("settle_busy", bus.busy_o, 1);
        tick();
        bus.tie_break_i = ~tie;
        #3;
        chk("out_valid", bus.result_valid_o, 1);
        chk("out_result", bus.result_o, expv);
        if (mode == 0) chk("latency", cyc - k0, n + 3);
        for (int h = 0; h < hold; h++) begin
            bus.start_i = (h == 1);
            tick();
            bus.start_i = 1'b0;
            #3;
            chk("hold_valid", bus.result_valid_o, 1);
            chk("hold_result", bus.result_o, expv);
        end
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        #3;
        chk("done_busy", bus.busy_o, 0);
        chk("done_valid", bus.result_valid_o, 0);
        chk("done_left", bus.items_left_o, 0);
    endtask

    initial begin
        logic [HVD-1:0] t;
        int n;
        rst_n              = 1'b0;
        bus.start_i        = 1'b0;
        bus.abort_i        = 1'b0;
        bus.num_items_i    = '0;
        bus.tie_break_i    = '0;
        bus.hv_i           = '0;
        bus.hv_valid_i     = 1'b0;
        bus.result_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", bus.result_o, 0);
        chk("rst_valid", bus.result_valid_o, 0);
        chk("rst_left", bus.items_left_o, 0);
        chk("rst_ready", bus.hv_ready_o, 0);
        chk("rst_bvalid", bus.bund_valid_o, 0);
        chk("rst_clr", bus.bund_clr_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        rst_n = 1'b1;
        tick();

        q_items = '{8'hF0, 8'hF0, 8'h0F};
        run_job(3, HVD'($urandom), 0, 0);

        q_items = '{8'hFF, 8'h00};
        run_job(2, 8'hA5, 0, 0);

        q_items = {};
        repeat (4) q_items.push_back(HVD'($urandom));
        run_job(4, HVD'($urandom), 1, 0);

        q_items = '{8'h3C, 8'h3C, 8'hC3};
        run_job(3, HVD'($urandom), 0, 5);

        q_items = {};
        t = HVD'($urandom);
        run_job(0, t, 0, 0);

        // Abort after two of five accepted items
        tick();
        bus.num_items_i = 16'd5;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.hv_valid_i = 1'b1;
            bus.hv_i       = HVD'($urandom);
            tick();
        end
        bus.abort_i = 1'b1;
        #3;
        chk("abort_ready", bus.hv_ready_o, 0);
        chk("abort_bvalid", bus.bund_valid_o, 0);
        chk("abort_clr", bus.bund_clr_o, 1);
        chk("abort_left", bus.items_left_o, 3);
        tick();
        bus.abort_i    = 1'b0;
        bus.hv_valid_i = 1'b0;
        #3;
        chk("post_abort_busy", bus.busy_o, 0);
        chk("post_abort_left", bus.items_left_o, 0);
        for (int i = 0; i < 3; i++) begin
            chk("post_abort_valid", bus.result_valid_o, 0);
            tick();
        end

        // Abort while idle only pulses the clear
        bus.abort_i = 1'b1;
        #3;
        chk("idle_abort_clr", bus.bund_clr_o, 1);
        chk("idle_abort_busy", bus.busy_o, 0);
        tick();
        bus.abort_i = 1'b0;
        #3;
        chk("idle_abort_after", bus.busy_o, 0);

        q_items = '{8'hFF};
        run_job(1, HVD'($urandom), 0, 0);

        q_items = {};
        repeat (300) q_items.push_back(8'hFF);
        run_job(300, HVD'($urandom), 0, 1);

        for (int j = 0; j < 5; j++) begin
            n = int'($urandom_range(1, 6));
            q_items = {};
            repeat (n) q_items.push_back(HVD'($urandom));
            run_job(n, HVD'($urandom), 2, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bundler_ctrl.md
Name: bundler_ctrl

Overview:
Sequencer for an array of HVDimension bundler units (per-bit saturating signed counters). Clears the array and streams a programmed number of hypervectors into it over a valid/ready handshake. It then binarizes the counters (sign threshold, tie-break vector on zero) and presents one result hypervector downstream. It sits between the encoder item stream and the associative-memory and query path.

Parameters:
HVDimension, 512, hypervector width and number of bundler units driven
CounterWidth, 8, width of each signed bundler counter read back
NumItemsWidth, 16, width of the item-count register

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  reset, asynchronous active-low
start_i  input  1  begin a bundling job (honoured in IDLE only)
abort_i  input  1  synchronous abort of the current job
num_items_i  input  NumItemsWidth  items to bundle, sampled on accepted start
tie_break_i  input  HVDimension  result bit used where the counter is exactly 0
hv_i  input  HVDimension  item hypervector
hv_valid_i  input  1  item valid
hv_ready_o  output  1  item ready
bund_bit_o  output  HVDimension  bit_i to the bundler array
bund_valid_o  output  1  valid_i to all bundler units
bund_clr_o  output  1  clr_i to all bundler units
counters_i  input  HVDimension*CounterWidth  flattened bundler counters, unit d at bits [d*CounterWidth +: CounterWidth]
result_o  output  HVDimension  binarized bundle
result_valid_o  output  1  result valid
result_ready_i  input  1  result ready
busy_o  output  1  high in every state except IDLE
items_left_o  output  NumItemsWidth  items remaining in the current job

Behaviour:
- Reset values (async, rst_ni low): state IDLE; result_o 0; result_valid_o 0; items_left_o 0; hv_ready_o 0; bund_valid_o 0; bund_clr_o 0; busy_o 0.
- States:
  - IDLE -> CLEAR on start_i. On that edge, latch items_left <= num_items_i.
  - CLEAR: bund_clr_o=1 for exactly one cycle. Next state is ACCUM if items_left != 0, else SETTLE.
  - ACCUM: hv_ready_o=1.
    - On hv_valid_i && hv_ready_o: bund_valid_o=1 and bund_bit_o=hv_i, combinationally in the same cycle; items_left decrements.
    - When the accepted item makes items_left 0, next state is SETTLE.
    - No handshake: bund_valid_o=0, state held.
  - SETTLE: exactly one cycle; the last counter update is now visible on counters_i. On exit, register result_o; next state is OUTPUT.
  - OUTPUT: result_valid_o=1, with result_o stable until result_ready_i. The handshake returns the block to IDLE.
- Counters are not cleared after output. The array keeps the sums until the next job's CLEAR.
- Binarization, per position d, with the counter treated as signed:
  - counter > 0 -> 1
  - counter < 0 -> 0
  - counter == 0 -> tie_break_i[d], sampled in the SETTLE cycle.
- bund_bit_o = hv_i in all states; only bund_valid_o qualifies it. hv_ready_o=0 outside ACCUM.
- Latency: an N-item job with no stalls has result_valid_o high at cycle N+3 after the start cycle (start edge, CLEAR, N ACCUM cycles, SETTLE). num_items_i=0 gives result_valid_o at cycle 3, with result = tie_break_i.
- start_i outside IDLE is ignored and does not queue.
- abort_i in any non-IDLE state:
  - next state IDLE; bund_clr_o=1 in the abort cycle; items_left <= 0;
  - no item is accepted (hv_ready_o forced 0 in that cycle); result_valid_o drops.
  - abort_i in IDLE is a no-op apart from bund_clr_o=1.
  - abort_i has priority over start_i and over every handshake.
- rst_ni low mid-job returns everything to its reset values immediately. The bundler array is reset by the same rst_ni.
- Saturation is handled inside the bundler units; this block only reads the sign.

Test Plan:
- Reset, then start with num_items=3, items 0xF0.., 0xF0.., 0x0F.. (HVDimension=8, CounterWidth=8) -> one clr pulse; counters +1 on bits[7:4], -1 on bits[3:0]; result_o=0xF0; result_valid_o at cycle 6.
- num_items=2 with one item of all ones and one all zeros, tie_break_i=0xA5 -> all counters 0; result_o=0xA5.
- num_items=4 with hv_valid_i toggling 1,0,1,0,... -> only 4 handshakes counted; items_left_o goes 4,3,2,1,0; result valid only after the 4th accept plus SETTLE.
- result_ready_i held low 5 cycles in OUTPUT; start_i pulsed meanwhile -> result_o stable, start ignored; IDLE one cycle after ready.
- abort_i asserted after 2 of 5 items -> bund_clr_o=1, IDLE next cycle, no result_valid_o; a new job of 1 item (0xFF) -> result 0xFF.
- num_items=300 of all ones, CounterWidth=8 -> counters saturate at 127; result all ones; items_left reaches 0 exactly after 300 accepts.
